// File: rtl/camac_pkg.sv
// Shared encodings, dataway limits and FSM states for the CAMAC dataway master.
package camac_pkg;

    localparam logic [1:0] OP_NAF = 2'd0;
    localparam logic [1:0] OP_Z   = 2'd1;
    localparam logic [1:0] OP_C   = 2'd2;

    localparam logic [4:0] F_READ_MAX  = 5'd7;
    localparam logic [4:0] F_WRITE_MIN = 5'd16;
    localparam logic [4:0] F_WRITE_MAX = 5'd23;
    localparam logic [4:0] N_MAX       = 5'd23;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STB1,
        ST_GAP,
        ST_STB2,
        ST_HOLD,
        ST_RESP
    } state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/camac_phase_timer.sv
// Loadable down-counter; done_o marks the last clock of the loaded phase.
module camac_phase_timer #(
    parameter int unsigned W = 3
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;

    // Load on phase entry, then count down to zero and stay there.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/camac_dataway_master.sv
// CAMAC crate-controller dataway initiator: N/A/F, Z and C cycles with B/S1/S2 timing.
module camac_dataway_master
    import camac_pkg::*;
#(
    parameter int unsigned SETUP_CLK = 4,
    parameter int unsigned S1_CLK    = 2,
    parameter int unsigned GAP_CLK   = 1,
    parameter int unsigned S2_CLK    = 2,
    parameter int unsigned HOLD_CLK  = 1,
    parameter int unsigned DATA_W    = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [4:0]        cmd_n,
    input  logic [3:0]        cmd_a,
    input  logic [4:0]        cmd_f,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic [4:0]        n,
    output logic [3:0]        a,
    output logic [4:0]        f,
    output logic              b,
    output logic              s1,
    output logic              s2,
    output logic              z,
    output logic              c,
    output logic [DATA_W-1:0] write,
    input  logic [DATA_W-1:0] read,
    input  logic              q,
    input  logic              x,
    input  logic              lam,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_q,
    output logic              rsp_x,
    output logic              rsp_err,
    output logic              lam_sync
);

    localparam int unsigned PH_MAX = max_u(max_u(max_u(SETUP_CLK, S1_CLK), max_u(GAP_CLK, S2_CLK)), HOLD_CLK);
    localparam int unsigned PH_W   = $clog2(PH_MAX + 1);

    state_e              state_q, state_d;
    logic [1:0]          op_q;
    logic [4:0]          n_q, f_q;
    logic [3:0]          a_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   samp_rdata_q;
    logic                samp_q_q, samp_x_q;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_q_q, rsp_q_d, rsp_x_q, rsp_x_d, rsp_err_q, rsp_err_d;
    logic                lam_meta_q, lam_sync_q;
    logic                tmr_load;
    logic [PH_W-1:0]     tmr_val;
    logic                tmr_done;

    logic accept, in_naf, in_bad_n, op_naf, active;

    assign accept   = cmd_valid && (state_q == ST_IDLE);
    assign in_naf   = (cmd_op != OP_Z) && (cmd_op != OP_C);
    assign in_bad_n = (cmd_n == 5'd0) || (cmd_n > N_MAX);
    assign op_naf   = (op_q != OP_Z) && (op_q != OP_C);
    assign active   = (state_q == ST_SETUP) || (state_q == ST_STB1) || (state_q == ST_GAP)
                   || (state_q == ST_STB2) || (state_q == ST_HOLD);

    camac_phase_timer #(.W(PH_W)) u_timer (
        .clk_i      (clk),
        .rst_ni     (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    // Dataway outputs decode straight from the state register so reset clears them at once.
    assign cmd_ready = (state_q == ST_IDLE);
    assign b         = active;
    assign s1        = (state_q == ST_STB1) && op_naf;
    assign s2        = (state_q == ST_STB2);
    assign z         = active && (op_q == OP_Z);
    assign c         = active && (op_q == OP_C);
    assign n         = (active && op_naf) ? n_q : '0;
    assign a         = (active && op_naf) ? a_q : '0;
    assign f         = (active && op_naf) ? f_q : '0;
    assign write     = (active && op_naf && (f_q >= F_WRITE_MIN) && (f_q <= F_WRITE_MAX)) ? wdata_q : '0;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_q     = rsp_q_q;
    assign rsp_x     = rsp_x_q;
    assign rsp_err   = rsp_err_q;
    assign lam_sync  = lam_sync_q;

    // Next-state, phase timer loading and response formation on entry to RESP.
    always_comb begin
        state_d     = state_q;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_q_d     = rsp_q_q;
        rsp_x_d     = rsp_x_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (in_naf && in_bad_n) begin
                        state_d     = ST_RESP;
                        rsp_rdata_d = '0;
                        rsp_q_d     = 1'b0;
                        rsp_x_d     = 1'b0;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d  = ST_SETUP;
                        tmr_load = 1'b1;
                        tmr_val  = PH_W'(SETUP_CLK);
                    end
                end
            end
            ST_SETUP: begin
                if (tmr_done) begin
                    state_d  = ST_STB1;
                    tmr_load = 1'b1;
                    tmr_val  = PH_W'(S1_CLK);
                end
            end
            ST_STB1: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    if (GAP_CLK == 0) begin
                        state_d = ST_STB2;
                        tmr_val = PH_W'(S2_CLK);
                    end else begin
                        state_d = ST_GAP;
                        tmr_val = PH_W'(GAP_CLK);
                    end
                end
            end
            ST_GAP: begin
                if (tmr_done) begin
                    state_d  = ST_STB2;
                    tmr_load = 1'b1;
                    tmr_val  = PH_W'(S2_CLK);
                end
            end
            ST_STB2: begin
                if (tmr_done) begin
                    state_d  = ST_HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = PH_W'(HOLD_CLK);
                end
            end
            ST_HOLD: begin
                if (tmr_done) begin
                    state_d = ST_RESP;
                    if (op_naf) begin
                        rsp_rdata_d = (f_q <= F_READ_MAX) ? samp_rdata_q : '0;
                        rsp_q_d     = samp_q_q;
                        rsp_x_d     = samp_x_q;
                        rsp_err_d   = !samp_x_q;
                    end else begin
                        rsp_rdata_d = '0;
                        rsp_q_d     = 1'b0;
                        rsp_x_d     = 1'b0;
                        rsp_err_d   = 1'b0;
                    end
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, command latch, STB1 sampler and response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_NAF;
            n_q          <= '0;
            a_q          <= '0;
            f_q          <= '0;
            wdata_q      <= '0;
            samp_rdata_q <= '0;
            samp_q_q     <= 1'b0;
            samp_x_q     <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_q_q      <= 1'b0;
            rsp_x_q      <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_q_q     <= rsp_q_d;
            rsp_x_q     <= rsp_x_d;
            rsp_err_q   <= rsp_err_d;
            if (accept) begin
                op_q    <= cmd_op;
                n_q     <= cmd_n;
                a_q     <= cmd_a;
                f_q     <= cmd_f;
                wdata_q <= cmd_wdata;
            end
            if ((state_q == ST_STB1) && tmr_done) begin
                samp_rdata_q <= read;
                samp_q_q     <= q;
                samp_x_q     <= x;
            end
        end
    end

    // Two-flop synchroniser for the asynchronous LAM line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lam_meta_q <= 1'b0;
            lam_sync_q <= 1'b0;
        end else begin
            lam_meta_q <= lam;
            lam_sync_q <= lam_meta_q;
        end
    end

endmodule

// File: tb/tb_camac_dataway_master.sv
// Directed bench for camac_dataway_master with hand-computed expectations.
module tb_camac_dataway_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_n;
    logic [3:0]  cmd_a;
    logic [4:0]  cmd_f;
    logic [23:0] cmd_wdata;
    logic [4:0]  n;
    logic [3:0]  a;
    logic [4:0]  f;
    logic        b, s1, s2, z, c;
    logic [23:0] write;
    logic [23:0] read;
    logic        q, x, lam;
    logic        rsp_valid;
    logic [23:0] rsp_rdata;
    logic        rsp_q, rsp_x, rsp_err;
    logic        lam_sync;

    int total = 0;
    int bad   = 0;

    // Per-cycle capture; index k = k-th clock after the accepting edge.
    logic [32:0] b_v, s1_v, s2_v, z_v, c_v, rv_v, rdy_v, rq_v, rx_v, re_v;
    logic [23:0] wr_a [1:32];
    logic [23:0] rd_a [1:32];
    logic [4:0]  n_a  [1:32];
    logic [4:0]  f_a  [1:32];
    logic [23:0] wr_or;

    camac_dataway_master dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_n(cmd_n), .cmd_a(cmd_a), .cmd_f(cmd_f), .cmd_wdata(cmd_wdata),
        .n(n), .a(a), .f(f), .b(b), .s1(s1), .s2(s2), .z(z), .c(c),
        .write(write), .read(read), .q(q), .x(x), .lam(lam),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_q(rsp_q), .rsp_x(rsp_x),
        .rsp_err(rsp_err), .lam_sync(lam_sync)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [4:0] nn, input logic [3:0] aa,
                         input logic [4:0] ff, input logic [23:0] wd, input bit keep);
        cmd_op = op; cmd_n = nn; cmd_a = aa; cmd_f = ff; cmd_wdata = wd;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic monitor(input int ncyc);
        b_v = '0; s1_v = '0; s2_v = '0; z_v = '0; c_v = '0;
        rv_v = '0; rdy_v = '0; rq_v = '0; rx_v = '0; re_v = '0; wr_or = '0;
        for (int k = 1; k <= ncyc; k++) begin
            if (k > 1 && rdy_v[k-1]) cmd_valid = 1'b0;
            b_v[k] = b; s1_v[k] = s1; s2_v[k] = s2; z_v[k] = z; c_v[k] = c;
            rv_v[k] = rsp_valid; rdy_v[k] = cmd_ready;
            rq_v[k] = rsp_q; rx_v[k] = rsp_x; re_v[k] = rsp_err;
            wr_a[k] = write; rd_a[k] = rsp_rdata; n_a[k] = n; f_a[k] = f;
            wr_or = wr_or | write;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_n = '0; cmd_a = '0; cmd_f = '0;
        cmd_wdata = '0; read = '0; q = 1'b0; x = 1'b0; lam = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_b", 32'(b), 32'd0);
        check("rst_strobes", 32'({s1, s2, z, c}), 32'd0);
        check("rst_naf", 32'({n, a, f}), 32'd0);
        check("rst_write", 32'(write), 32'd0);
        check("rst_rsp", 32'({rsp_valid, rsp_q, rsp_x, rsp_err}), 32'd0);
        check("rst_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_lam", 32'(lam_sync), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Write N=1 A=0 F=16
        read = '0; q = 1'b0; x = 1'b1;
        issue(2'd0, 5'd1, 4'd0, 5'd16, 24'h00ABCD, 1'b0);
        monitor(12);
        check("wr_s1_window", 32'(s1_v[7:4]), 32'b0110);
        check("wr_write_s1a", 32'(wr_a[5]), 32'h00ABCD);
        check("wr_write_s1b", 32'(wr_a[6]), 32'h00ABCD);
        check("wr_b_window", 32'(b_v[12:1]), 32'h3FF);
        check("wr_s2_window", 32'(s2_v[12:1]), 32'h180);
        check("wr_naf", 32'({n_a[1], f_a[1]}), 32'({5'd1, 5'd16}));
        check("wr_rsp_cycle", 32'(rv_v[12:1]), 32'h400);
        check("wr_rsp_x", 32'(rx_v[11]), 32'd1);
        check("wr_rsp_err", 32'(re_v[11]), 32'd0);
        check("wr_rsp_rdata", 32'(rd_a[11]), 32'd0);
        check("wr_ready_back", 32'(rdy_v[12:10]), 32'b100);

        // Read F=0, write data must not reach W lines
        read = 24'h123456; q = 1'b1; x = 1'b1;
        issue(2'd0, 5'd2, 4'd3, 5'd0, 24'hFFFFFF, 1'b0);
        monitor(12);
        check("rd_rdata", 32'(rd_a[11]), 32'h123456);
        check("rd_q", 32'(rq_v[11]), 32'd1);
        check("rd_err", 32'(re_v[11]), 32'd0);
        check("rd_write_zero", 32'(wr_or), 32'd0);

        // Control F=27 with q=0 then q=1
        read = 24'hAAAAAA; q = 1'b0; x = 1'b1;
        issue(2'd0, 5'd4, 4'd1, 5'd27, 24'h0, 1'b0);
        monitor(12);
        check("ctl1_q", 32'(rq_v[11]), 32'd0);
        check("ctl1_rdata", 32'(rd_a[11]), 32'd0);
        q = 1'b1;
        issue(2'd0, 5'd4, 4'd1, 5'd27, 24'h0, 1'b0);
        monitor(12);
        check("ctl2_q", 32'(rq_v[11]), 32'd1);
        check("ctl2_rdata", 32'(rd_a[11]), 32'd0);
        check("ctl2_q_held", 32'({rv_v[12], rq_v[12]}), 32'b01);

        // No X response
        read = '0; q = 1'b0; x = 1'b0;
        issue(2'd0, 5'd5, 4'd0, 5'd9, 24'h0, 1'b0);
        monitor(12);
        check("nox_rsp_cycle", 32'(rv_v[12:1]), 32'h400);
        check("nox_err", 32'(re_v[11]), 32'd1);
        check("nox_x", 32'(rx_v[11]), 32'd0);

        // Illegal station numbers skip the dataway cycle
        q = 1'b1; x = 1'b1;
        issue(2'd0, 5'd0, 4'd0, 5'd0, 24'h0, 1'b0);
        monitor(4);
        check("n0_no_b", 32'(b_v), 32'd0);
        check("n0_no_s1", 32'(s1_v), 32'd0);
        check("n0_rsp_cycle", 32'(rv_v[3:1]), 32'b001);
        check("n0_err", 32'(re_v[1]), 32'd1);
        check("n0_qx", 32'({rq_v[1], rx_v[1]}), 32'd0);
        issue(2'd3, 5'd24, 4'd0, 5'd0, 24'h0, 1'b0);
        monitor(3);
        check("n24_rsp", 32'({b_v[1], rv_v[1], re_v[1]}), 32'b011);

        // Z cycle with a read command held on cmd_valid throughout
        read = 24'h55AA55; q = 1'b1; x = 1'b1;
        issue(2'd1, 5'd7, 4'd2, 5'd16, 24'h777777, 1'b1);
        cmd_op = 2'd0; cmd_n = 5'd3; cmd_a = 4'd1; cmd_f = 5'd0; cmd_wdata = 24'h0;
        monitor(25);
        check("z_window", 32'(z_v[12:1]), 32'h3FF);
        check("z_b_window", 32'(b_v[12:1]), 32'h3FF);
        check("z_s2", 32'(s2_v[12:1]), 32'h180);
        check("z_no_s1", 32'(s1_v[12:1]), 32'd0);
        check("z_no_c", 32'(c_v), 32'd0);
        check("z_naf_zero", 32'({n_a[5], f_a[5]}), 32'd0);
        check("z_write_zero", 32'(wr_a[5]), 32'd0);
        check("z_rsp", 32'({rv_v[11], rq_v[11], rx_v[11], re_v[11]}), 32'b1000);
        check("z_ready_only_12", 32'(rdy_v[12:1]), 32'h800);
        check("held_b_start", 32'(b_v[13]), 32'd1);
        check("held_rsp_cycle", 32'(rv_v[25:13]), 32'h0400);
        check("held_rdata", 32'(rd_a[23]), 32'h55AA55);

        // C cycle
        issue(2'd2, 5'd2, 4'd0, 5'd0, 24'h0, 1'b0);
        monitor(12);
        check("c_window", 32'(c_v[12:1]), 32'h3FF);
        check("c_no_zs1", 32'(z_v | s1_v), 32'd0);
        check("c_rsp", 32'({rv_v[11], rq_v[11], rx_v[11], re_v[11]}), 32'b1000);

        // Asynchronous reset during STB1
        issue(2'd0, 5'd6, 4'd0, 5'd17, 24'h0F0F0F, 1'b0);
        monitor(5);
        check("mid_s1_before", 32'(s1), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("mid_s1_b", 32'({s1, b, z}), 32'd0);
        check("mid_write", 32'(write), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        monitor(15);
        check("mid_no_rsp", 32'(rv_v), 32'd0);
        check("mid_idle", 32'(rdy_v[1]), 32'd1);

        // LAM synchroniser
        lam = 1'b1;
        @(posedge clk); #1;
        check("lam_1clk", 32'(lam_sync), 32'd0);
        @(posedge clk); #1;
        check("lam_2clk", 32'(lam_sync), 32'd1);
        lam = 1'b0;
        @(posedge clk); #1;
        check("lam_fall_1clk", 32'(lam_sync), 32'd1);
        @(posedge clk); #1;
        check("lam_fall_2clk", 32'(lam_sync), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
